// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader: host fills a shadow bank, which is copied to the
// active bank (coeff_flat) on the first edge in a sample gap after a well-formed frame.
module fir_coeff_loader #(
    parameter int NUM_COEFF = 16,
    parameter int COEFF_W   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [COEFF_W-1:0]             wr_data,
    input  logic                           wr_last,
    input  logic                           sample_enable,
    output logic [NUM_COEFF*COEFF_W-1:0]   coeff_flat,
    output logic                           busy,
    output logic                           commit_done,
    output logic                           frame_error
);

    localparam int IDX_W = $clog2(NUM_COEFF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PENDING} state_t;

    state_t             state, next_state;
    logic [IDX_W-1:0]   idx;
    logic [COEFF_W-1:0] shadow [NUM_COEFF];
    logic               accept, at_end, good_end, bad_end, commit;

    assign accept   = wr_valid && wr_ready;
    assign at_end   = (idx == LAST_IDX);
    assign good_end = accept && at_end && wr_last;
    // A frame is malformed if wr_last and the final slot disagree.
    assign bad_end  = accept && (at_end != wr_last);
    // Never swap banks while the filter stages are consuming a sample.
    assign commit   = (state == PENDING) && !sample_enable;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, LOAD: begin
                if (good_end)     next_state = PENDING;
                else if (bad_end) next_state = IDLE;
                else if (accept)  next_state = LOAD;
            end
            PENDING: if (commit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state != PENDING);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            commit_done <= 1'b0;
            frame_error <= 1'b0;
            coeff_flat  <= '0;
            for (int k = 0; k < NUM_COEFF; k++) shadow[k] <= '0;
        end else begin
            commit_done <= commit;
            if (accept) shadow[idx] <= wr_data;
            // Index only advances while a frame is open; any exit restarts it at slot 0.
            if (next_state == LOAD) idx <= idx + IDX_W'(accept);
            else                    idx <= '0;
            if (bad_end)     frame_error <= 1'b1;
            else if (commit) frame_error <= 1'b0;
            if (commit) begin
                for (int k = 0; k < NUM_COEFF; k++)
                    coeff_flat[COEFF_W*k +: COEFF_W] <= shadow[k];
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: a frame table plus hand sequences for PENDING and mid-frame reset.
module tb_fir_coeff_loader;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int FW = N * W;

    logic          clk = 1'b0;
    logic          reset, wr_valid, wr_ready, wr_last, sample_enable;
    logic          busy, commit_done, frame_error;
    logic [W-1:0]  wr_data;
    logic [FW-1:0] coeff_flat;
    logic [FW-1:0] exp_flat;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int n;         // words sent
        int last_pos;  // word carrying wr_last (1-based), 0 = none
        int base;      // slot k receives base + k
        int hold;      // edges sample_enable stays high after the final word
        int gap_at;    // idle cycle inserted after this word, 0 = none
        bit exp_err;   // frame expected to be rejected
    } frame_vec_t;

    frame_vec_t vecs[6];

    fir_coeff_loader #(.NUM_COEFF(N), .COEFF_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .sample_enable (sample_enable),
        .coeff_flat    (coeff_flat),
        .busy          (busy),
        .commit_done   (commit_done),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_exp(input int base);
        for (int k = 0; k < N; k++) exp_flat[W*k +: W] = W'(base + k);
    endtask

    task automatic send_frame(input int n, input int last_pos, input int base, input int gap_at);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = W'(base + i);
            wr_last  = (i + 1 == last_pos);
            tick();
            if (gap_at != 0 && i + 1 == gap_at) begin
                wr_valid = 1'b0;
                wr_last  = 1'b0;
                wr_data  = 16'hFFFF;
                tick();
            end
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Called right after the edge that entered PENDING (or the last held edge) with sample_enable=0.
    task automatic finish_commit(input string tag, input int base);
        @(negedge clk);
        check({tag, " pend busy"}, FW'(busy), FW'(1));
        check({tag, " pend ready"}, FW'(wr_ready), FW'(0));
        check({tag, " pend done"}, FW'(commit_done), FW'(0));
        check({tag, " pend flat"}, coeff_flat, exp_flat);
        tick();
        fill_exp(base);
        @(negedge clk);
        check({tag, " commit_done"}, FW'(commit_done), FW'(1));
        check({tag, " commit busy"}, FW'(busy), FW'(0));
        check({tag, " commit ferr"}, FW'(frame_error), FW'(0));
        check({tag, " commit flat"}, coeff_flat, exp_flat);
        tick();
        @(negedge clk);
        check({tag, " done pulse end"}, FW'(commit_done), FW'(0));
    endtask

    initial begin
        vecs[0] = '{n: 16, last_pos: 16, base: 'h0001, hold: 0, gap_at: 0, exp_err: 1'b0};
        vecs[1] = '{n: 16, last_pos: 16, base: 'h0101, hold: 5, gap_at: 0, exp_err: 1'b0};
        vecs[2] = '{n: 10, last_pos: 10, base: 'h0200, hold: 0, gap_at: 0, exp_err: 1'b1};
        vecs[3] = '{n: 16, last_pos: 16, base: 'h0301, hold: 0, gap_at: 0, exp_err: 1'b0};
        vecs[4] = '{n: 16, last_pos: 0,  base: 'h0400, hold: 0, gap_at: 0, exp_err: 1'b1};
        vecs[5] = '{n: 16, last_pos: 16, base: 'h0501, hold: 2, gap_at: 7, exp_err: 1'b0};

        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; sample_enable = 1'b0;
        exp_flat = '0;
        tick();
        tick();
        @(negedge clk);
        check("reset flat", coeff_flat, '0);
        check("reset busy", FW'(busy), FW'(0));
        check("reset done", FW'(commit_done), FW'(0));
        check("reset ferr", FW'(frame_error), FW'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post reset ready", FW'(wr_ready), FW'(1));
        tick();

        foreach (vecs[v]) begin
            sample_enable = (vecs[v].hold > 0);
            send_frame(vecs[v].n, vecs[v].last_pos, vecs[v].base, vecs[v].gap_at);
            if (vecs[v].exp_err) begin
                @(negedge clk);
                check($sformatf("v%0d ferr", v), FW'(frame_error), FW'(1));
                check($sformatf("v%0d busy", v), FW'(busy), FW'(0));
                check($sformatf("v%0d ready", v), FW'(wr_ready), FW'(1));
                check($sformatf("v%0d flat kept", v), coeff_flat, exp_flat);
                tick();
            end else begin
                for (int h = 0; h < vecs[v].hold; h++) begin
                    @(negedge clk);
                    check($sformatf("v%0d hold%0d flat", v, h), coeff_flat, exp_flat);
                    check($sformatf("v%0d hold%0d done", v, h), FW'(commit_done), FW'(0));
                    tick();
                end
                sample_enable = 1'b0;
                finish_commit($sformatf("v%0d", v), vecs[v].base);
            end
        end

        // Writes offered while PENDING must be refused and leave no trace.
        sample_enable = 1'b1;
        send_frame(16, 16, 'h0601, 0);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 16'hDEAD; wr_last = 1'b1;
            @(negedge clk);
            check($sformatf("pend ignore%0d ready", i), FW'(wr_ready), FW'(0));
            check($sformatf("pend ignore%0d ferr", i), FW'(frame_error), FW'(0));
            tick();
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        sample_enable = 1'b0;
        finish_commit("pend ignore", 'h0601);

        // Leave a sticky error, start a frame, then reset over an in-flight word.
        send_frame(3, 3, 'h0900, 0);
        @(negedge clk);
        check("pre-reset ferr", FW'(frame_error), FW'(1));
        tick();
        send_frame(8, 0, 'h0700, 0);
        reset = 1'b1; wr_valid = 1'b1; wr_data = 16'hBEEF; wr_last = 1'b1;
        tick();
        reset = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
        exp_flat = '0;
        @(negedge clk);
        check("midreset flat", coeff_flat, '0);
        check("midreset busy", FW'(busy), FW'(0));
        check("midreset done", FW'(commit_done), FW'(0));
        check("midreset ferr", FW'(frame_error), FW'(0));
        check("midreset ready", FW'(wr_ready), FW'(1));
        tick();
        send_frame(16, 16, 'h0801, 0);
        finish_commit("after reset", 'h0801);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
